// File: rtl/ex_lsu_issue.sv
// ex_lsu_issue: execute-stage load/store issuer with aligned address, byte strobes, replicated
// store data, hold-until-accepted memory request and an outstanding-request counter.
// Ports:
//   clk, rst_n (async, active low), flush (kills the held op only)
//   in_*   : op from ID (valid/ready, load, store, ls_type, addr, wdata, dest)
//   mem_*  : request to data memory (valid/ready, wen, addr, wstrb, wdata) and mem_rsp_valid
//   out_*  : completed op to MEM (valid/ready, misalign, offset, ls_type, dest)
//   outstanding : issued-but-unanswered request count
module ex_lsu_issue #(
  parameter int XLEN    = 32,
  parameter int AW      = 32,
  parameter int MAX_OUT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_load,
  input  logic              in_store,
  input  logic [2:0]        in_ls_type,
  input  logic [AW-1:0]     in_addr,
  input  logic [XLEN-1:0]   in_wdata,
  input  logic [4:0]        in_dest,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_wen,
  output logic [AW-1:0]     mem_addr,
  output logic [XLEN/8-1:0] mem_wstrb,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_rsp_valid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_misalign,
  output logic [2:0]        out_offset,
  output logic [2:0]        out_ls_type,
  output logic [4:0]        out_dest,
  output logic [2:0]        outstanding
);
  localparam int STRB = XLEN / 8;
  localparam int OB   = $clog2(STRB);
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
  state_t state, state_nx;
  logic            acc, fire, dec, is_mem, st_op, illegal, mis, go_issue;
  logic [1:0]      sz;
  logic [OB-1:0]   o, lowm;
  logic [STRB-1:0] base, strb;
  logic [XLEN-1:0] wdata;
  // Operand decode: access size is ls_type[1:0]; the lane mask is the size-wide
  // base pattern shifted to the naturally aligned slot containing the address.
  always_comb begin
    is_mem   = in_load | in_store;
    st_op    = in_store & ~in_load;
    sz       = in_ls_type[1:0];
    o        = in_addr[OB-1:0];
    lowm     = OB'((1 << sz) - 1);
    illegal  = (in_ls_type == 3'b111) | ((XLEN == 32) & ((in_ls_type == 3'b011) | (in_ls_type == 3'b110)));
    mis      = is_mem & (illegal | ((o & lowm) != '0));
    go_issue = is_mem & ~mis;
    base     = sz == 2'd0 ? STRB'(1) : sz == 2'd1 ? STRB'(3) : sz == 2'd2 ? STRB'(15) : '1;
    strb     = st_op ? base << (o & ~lowm) : '1;
    wdata    = sz == 2'd0 ? {STRB{in_wdata[7:0]}} :
               sz == 2'd1 ? {(STRB/2){in_wdata[15:0]}} :
               sz == 2'd2 ? {(XLEN/32){in_wdata[31:0]}} : in_wdata;
  end
  // flush wins over a same-cycle accept
  assign acc  = in_valid & in_ready & ~flush;
  assign fire = mem_req_valid & mem_req_ready;
  assign dec  = mem_rsp_valid & (outstanding != 3'd0);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = acc ? (go_issue ? ISSUE : DONE) : IDLE;
      ISSUE:   state_nx = flush ? IDLE : fire ? DONE : ISSUE;
      DONE:    state_nx = flush ? IDLE : acc ? (go_issue ? ISSUE : DONE) : out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    in_ready      = (state == IDLE) | ((state == DONE) & out_ready);
    mem_req_valid = (state == ISSUE) & (outstanding < 3'(MAX_OUT));
    out_valid     = state == DONE;
  end
  // A request accepted in a flush cycle is still in flight, so it is counted regardless.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) outstanding <= 3'd0;
    else outstanding <= outstanding + 3'(fire) - 3'(dec);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_wen      <= 1'b0;
      mem_addr     <= '0;
      mem_wstrb    <= '0;
      mem_wdata    <= '0;
      out_misalign <= 1'b0;
      out_offset   <= 3'd0;
      out_ls_type  <= 3'd0;
      out_dest     <= 5'd0;
    end else if (acc) begin
      mem_wen      <= st_op;
      mem_addr     <= {in_addr[AW-1:OB], {OB{1'b0}}};
      mem_wstrb    <= strb;
      mem_wdata    <= wdata;
      out_misalign <= mis;
      out_offset   <= in_addr[2:0];
      out_ls_type  <= in_ls_type;
      out_dest     <= in_dest;
    end
endmodule

// File: tb/tb_ex_lsu_issue.sv
// tb_ex_lsu_issue: scoreboard bench for ex_lsu_issue (64-bit main instance, 32-bit side instance)
module tb_ex_lsu_issue;
  typedef struct {logic wen; logic [31:0] addr; logic [7:0] strb; logic [63:0] wdata;} req_t;
  typedef struct {logic mis; logic [2:0] off; logic [2:0] ty; logic [4:0] dest;} out_t;
  logic clk = 0, rst_n = 0, flush = 0;
  logic in_valid = 0, in_load = 0, in_store = 0;
  logic [2:0] in_ls_type = 0;
  logic [31:0] in_addr = 0;
  logic [63:0] in_wdata = 0;
  logic [4:0] in_dest = 0;
  logic in_ready, mem_req_valid, mem_wen, out_valid, out_misalign;
  logic mem_req_ready = 1, mem_rsp_valid = 0, out_ready = 1;
  logic [31:0] mem_addr;
  logic [7:0] mem_wstrb;
  logic [63:0] mem_wdata;
  logic [2:0] out_offset, out_ls_type, outstanding;
  logic [4:0] out_dest;
  logic in_valid32 = 0, mem_req_ready32 = 1, mem_rsp_valid32 = 0, out_ready32 = 1;
  logic in_ready32, mem_req_valid32, mem_wen32, out_valid32, out_misalign32;
  logic [31:0] mem_addr32, mem_wdata32;
  logic [3:0] mem_wstrb32;
  logic [2:0] out_offset32, out_ls_type32, outstanding32;
  logic [4:0] out_dest32;
  int n_chk = 0, n_fail = 0;
  req_t req_q[$];
  out_t out_q[$];
  req_t rq;
  out_t oq;
  always #5 clk = ~clk;
  ex_lsu_issue #(.XLEN(64), .AW(32), .MAX_OUT(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_load(in_load), .in_store(in_store), .in_ls_type(in_ls_type), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_dest(in_dest), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_rsp_valid(mem_rsp_valid), .out_valid(out_valid),
    .out_ready(out_ready), .out_misalign(out_misalign), .out_offset(out_offset),
    .out_ls_type(out_ls_type), .out_dest(out_dest), .outstanding(outstanding)
  );
  ex_lsu_issue #(.XLEN(32), .AW(32), .MAX_OUT(2)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid32), .in_ready(in_ready32),
    .in_load(in_load), .in_store(in_store), .in_ls_type(in_ls_type), .in_addr(in_addr),
    .in_wdata(in_wdata[31:0]), .in_dest(in_dest), .mem_req_valid(mem_req_valid32),
    .mem_req_ready(mem_req_ready32), .mem_wen(mem_wen32), .mem_addr(mem_addr32),
    .mem_wstrb(mem_wstrb32), .mem_wdata(mem_wdata32), .mem_rsp_valid(mem_rsp_valid32),
    .out_valid(out_valid32), .out_ready(out_ready32), .out_misalign(out_misalign32),
    .out_offset(out_offset32), .out_ls_type(out_ls_type32), .out_dest(out_dest32),
    .outstanding(outstanding32)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] m_strb(input logic st, input logic [2:0] t, input logic [2:0] o);
    if (!st) return 8'hFF;
    case (t[1:0])
      2'd0:    return 8'h01 << o;
      2'd1:    return 8'h03 << {o[2:1], 1'b0};
      2'd2:    return 8'h0F << {o[2], 2'b00};
      default: return 8'hFF;
    endcase
  endfunction
  function automatic logic [63:0] m_wdata(input logic [2:0] t, input logic [63:0] d);
    case (t[1:0])
      2'd0:    return {8{d[7:0]}};
      2'd1:    return {4{d[15:0]}};
      2'd2:    return {2{d[31:0]}};
      default: return d;
    endcase
  endfunction
  function automatic logic m_mis(input logic [2:0] t, input logic [2:0] o);
    return (t == 3'b111) | ((t[1:0] == 2'd1) & o[0]) | ((t[1:0] == 2'd2) & (o[1:0] != 0)) |
           ((t[1:0] == 2'd3) & (o != 0));
  endfunction
  task automatic send(input logic ld, input logic st, input logic [2:0] ty, input logic [31:0] a,
                      input logic [63:0] d, input logic [4:0] ds, input bit push);
    int n = 0;
    logic mis;
    req_t r;
    out_t q;
    @(posedge clk); #1;
    in_load = ld; in_store = st; in_ls_type = ty; in_addr = a; in_wdata = d; in_dest = ds;
    in_valid = 1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept", in_ready, 1);
    if (push) begin
      mis = (ld | st) & m_mis(ty, a[2:0]);
      if ((ld | st) && !mis) begin
        r.wen = st & ~ld; r.addr = {a[31:3], 3'b000}; r.strb = m_strb(st & ~ld, ty, a[2:0]);
        r.wdata = m_wdata(ty, d);
        req_q.push_back(r);
      end
      q.mis = mis; q.off = a[2:0]; q.ty = ty; q.dest = ds;
      out_q.push_back(q);
    end
    @(posedge clk); #1;
    in_valid = 0;
  endtask
  task automatic rsp();
    @(posedge clk); #1;
    mem_rsp_valid = 1;
    @(posedge clk); #1;
    mem_rsp_valid = 0;
  endtask
  always @(negedge clk) if (rst_n) begin
    if (mem_req_valid && mem_req_ready) begin
      chk("req_expected", req_q.size() != 0, 1);
      if (req_q.size() != 0) begin
        rq = req_q.pop_front();
        chk("req_wen", mem_wen, rq.wen);
        chk("req_addr", mem_addr, rq.addr);
        chk("req_strb", mem_wstrb, rq.strb);
        if (rq.wen) chk("req_wdata", mem_wdata, rq.wdata);
      end
    end
    if (out_valid && out_ready) begin
      chk("out_expected", out_q.size() != 0, 1);
      if (out_q.size() != 0) begin
        oq = out_q.pop_front();
        chk("out_mis", out_misalign, oq.mis);
        chk("out_off", out_offset, oq.off);
        chk("out_ty", out_ls_type, oq.ty);
        chk("out_dest", out_dest, oq.dest);
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    #2;
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outstanding", outstanding, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_load = 0; in_store = 1; in_ls_type = 3'b000; in_addr = 32'h1003; in_wdata = 64'hA5; in_dest = 3;
    in_valid32 = 1;
    @(posedge clk); #1;
    in_valid32 = 0;
    chk("t1_req_valid", mem_req_valid32, 1);
    chk("t1_wen", mem_wen32, 1);
    chk("t1_addr", mem_addr32, 32'h1000);
    chk("t1_strb", mem_wstrb32, 4'b1000);
    chk("t1_wdata", mem_wdata32, 32'hA5A5A5A5);
    @(posedge clk); #1;
    chk("t1_outstanding", outstanding32, 1);
    chk("t1_out_valid", out_valid32, 1);
    chk("t1_req_once", mem_req_valid32, 0);
    chk("t1_offset", out_offset32, 3);
    @(posedge clk); #1;
    chk("t1_out_done", out_valid32, 0);
    in_load = 1; in_store = 0; in_ls_type = 3'b011; in_addr = 32'h1000; in_valid32 = 1;
    @(posedge clk); #1;
    in_valid32 = 0;
    chk("t1_ld32_mis", out_misalign32, 1);
    chk("t1_ld32_noreq", mem_req_valid32, 0);
    chk("t1_ld32_out", out_valid32, 1);
    send(0, 1, 3'b001, 32'h2006, 64'hBEEF, 5, 1);
    chk("t2_addr", mem_addr, 32'h2000);
    chk("t2_strb", mem_wstrb, 8'hC0);
    chk("t2_wdata", mem_wdata, 64'hBEEFBEEFBEEFBEEF);
    rsp();
    chk("t2_outstanding", outstanding, 0);
    send(1, 0, 3'b011, 32'h2004, 0, 6, 1);
    chk("t2_ld_mis", out_misalign, 1);
    chk("t2_ld_noreq", mem_req_valid, 0);
    send(1, 0, 3'b010, 32'h3000, 0, 1, 1);
    send(1, 0, 3'b010, 32'h3004, 0, 2, 1);
    send(1, 0, 3'b010, 32'h3008, 0, 3, 1);
    repeat (2) @(posedge clk); #1;
    chk("t3_stall_valid", mem_req_valid, 0);
    chk("t3_stall_cnt", outstanding, 2);
    chk("t3_stall_inrdy", in_ready, 0);
    mem_rsp_valid = 1;
    @(posedge clk); #1;
    mem_rsp_valid = 0;
    chk("t3_resume_valid", mem_req_valid, 1);
    chk("t3_resume_cnt", outstanding, 1);
    rsp();
    rsp();
    chk("t3_drain", outstanding, 0);
    rsp();
    chk("t3_no_underflow", outstanding, 0);
    mem_req_ready = 0;
    send(0, 1, 3'b010, 32'h4004, 64'h12345678, 4, 1);
    for (int i = 0; i < 5; i++) begin
      chk("t4_valid", mem_req_valid, 1);
      chk("t4_addr", mem_addr, 32'h4000);
      chk("t4_strb", mem_wstrb, 8'hF0);
      chk("t4_wdata", mem_wdata, 64'h1234567812345678);
      chk("t4_cnt0", outstanding, 0);
      @(posedge clk); #1;
    end
    mem_req_ready = 1;
    @(posedge clk); #1;
    chk("t4_cnt1", outstanding, 1);
    chk("t4_accepted", mem_req_valid, 0);
    rsp();
    out_ready = 0;
    send(1, 0, 3'b000, 32'h5001, 0, 7, 1);
    repeat (3) @(posedge clk); #1;
    chk("t5_hold_valid", out_valid, 1);
    chk("t5_hold_inrdy", in_ready, 0);
    chk("t5_hold_dest", out_dest, 7);
    in_load = 1; in_store = 0; in_ls_type = 3'b001; in_addr = 32'h5002; in_dest = 8;
    in_valid = 1; out_ready = 1;
    @(negedge clk);
    chk("t5_b2b_inrdy", in_ready, 1);
    rq.wen = 0; rq.addr = 32'h5000; rq.strb = 8'hFF; rq.wdata = 0;
    req_q.push_back(rq);
    oq.mis = 0; oq.off = 2; oq.ty = 3'b001; oq.dest = 8;
    out_q.push_back(oq);
    @(posedge clk); #1;
    in_valid = 0;
    chk("t5_next_req", mem_req_valid, 1);
    chk("t5_out_gone", out_valid, 0);
    rsp();
    rsp();
    chk("t5_cnt", outstanding, 0);
    for (int i = 0; i < 20; i++) begin
      logic [2:0] ty;
      logic [31:0] a;
      int k;
      ty = 3'($urandom_range(0, 7));
      a = 32'h7000 + 32'($urandom_range(0, 63));
      k = $urandom_range(0, 4);
      send(k == 1 || k == 2, k >= 3, ty, a, {$urandom, $urandom}, 5'(i), 1);
      if (k != 0 && !m_mis(ty, a[2:0])) begin
        rsp();
        chk("rand_cnt", outstanding, 0);
      end else @(posedge clk);
    end
    send(1, 0, 3'b010, 32'h6100, 0, 9, 1);
    @(posedge clk); #1;
    mem_req_ready = 0;
    send(0, 1, 3'b011, 32'h6000, 64'h0123456789ABCDEF, 10, 0);
    chk("t6_pre_valid", mem_req_valid, 1);
    chk("t6_pre_cnt", outstanding, 1);
    #3 rst_n = 0;
    #1;
    chk("t6_rst_valid", mem_req_valid, 0);
    chk("t6_rst_out", out_valid, 0);
    chk("t6_rst_cnt", outstanding, 0);
    chk("t6_rst_addr", mem_addr, 0);
    chk("t6_rst_wdata", mem_wdata, 0);
    chk("t6_rst_strb", mem_wstrb, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("t6_rel_inrdy", in_ready, 1);
    send(0, 1, 3'b010, 32'h6200, 64'h55, 11, 0);
    chk("t6_fl_pre", mem_req_valid, 1);
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    mem_req_ready = 1;
    chk("t6_fl_valid", mem_req_valid, 0);
    chk("t6_fl_out", out_valid, 0);
    chk("t6_fl_inrdy", in_ready, 1);
    repeat (3) @(posedge clk); #1;
    chk("t6_fl_cnt", outstanding, 0);
    chk("q_req_empty", req_q.size(), 0);
    chk("q_out_empty", out_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end
endmodule
